// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and issue.
// Upstream: valid_i/ready_o/inst_i/pc_i; downstream: valid_o/ready_i and the
// decoded bundle; flush_i redirects the stage.
interface decode_stage_if #(
  parameter int unsigned WORD_SIZE_P = 16,
  parameter int unsigned PC_WIDTH_P  = 16
);
  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [15:0]            inst_i;
  logic [PC_WIDTH_P-1:0]  pc_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [15:0]            inst_o;
  logic [PC_WIDTH_P-1:0]  pc_o;
  logic [2:0]             fmt_o;
  logic [WORD_SIZE_P-1:0] imm_o;
  logic [1:0]             count_o;

  // Fetch/issue side: drives instructions, flush and downstream ready.
  modport master (
    output flush_i, valid_i, inst_i, pc_i, ready_i,
    input  ready_o, valid_o, inst_o, pc_o, fmt_o, imm_o, count_o
  );

  // Decode stage side.
  modport slave (
    input  flush_i, valid_i, inst_i, pc_i, ready_i,
    output ready_o, valid_o, inst_o, pc_o, fmt_o, imm_o, count_o
  );
endinterface

// File: rtl/decode_stage.sv
// Registered immediate decode stage.
// Decodes the immediate of an incoming 16-bit instruction combinationally and
// stores {inst, pc, fmt, imm} in a 2-entry FIFO skid buffer. Outputs come from
// the head entry and read zero whenever the buffer is empty. ready_o depends
// only on registered occupancy, so back-pressure never reaches fetch
// combinationally.
module decode_stage #(
  parameter int unsigned WORD_SIZE_P   = 16,
  parameter int unsigned PC_WIDTH_P    = 16,
  parameter bit          SIGN_EXT_EN_P = 1'b1
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic [15:0]            inst;
    logic [PC_WIDTH_P-1:0]  pc;
    logic [2:0]             fmt;
    logic [WORD_SIZE_P-1:0] imm;
  } entry_t;

  entry_t                 mem [2];
  entry_t                 in_entry;
  entry_t                 head_entry;
  logic                   head;
  logic                   tail;
  logic [1:0]             count;
  logic                   enq;
  logic                   deq;
  logic [2:0]             fmt;
  logic [WORD_SIZE_P-1:0] imm;

  // Immediate selection and extension for the incoming instruction.
  always_comb begin
    fmt = bus.inst_i[15:13];
    imm = '0;
    unique case (fmt)
      3'd0: imm = WORD_SIZE_P'(bus.inst_i[7:0]);
      3'd1: imm = WORD_SIZE_P'(bus.inst_i[8:6]);
      3'd2: imm = WORD_SIZE_P'(bus.inst_i[6:0]);
      3'd3: imm = WORD_SIZE_P'(bus.inst_i[10:6]);
      3'd4: begin
        if (SIGN_EXT_EN_P) imm = WORD_SIZE_P'($signed(bus.inst_i[7:0]));
        else               imm = WORD_SIZE_P'(bus.inst_i[7:0]);
      end
      3'd5: begin
        if (SIGN_EXT_EN_P) imm = WORD_SIZE_P'($signed(bus.inst_i[10:0]));
        else               imm = WORD_SIZE_P'(bus.inst_i[10:0]);
      end
      3'd6: begin
        if (SIGN_EXT_EN_P) imm = WORD_SIZE_P'($signed(bus.inst_i[5:0]));
        else               imm = WORD_SIZE_P'(bus.inst_i[5:0]);
      end
      3'd7: imm = WORD_SIZE_P'(bus.inst_i[6:3]);
      default: imm = '0;
    endcase
  end

  // Assemble the entry written into the buffer.
  always_comb begin
    in_entry.inst = bus.inst_i;
    in_entry.pc   = bus.pc_i;
    in_entry.fmt  = fmt;
    in_entry.imm  = imm;
  end

  // Handshake terms; both depend only on registered occupancy plus the peer's signal.
  always_comb begin
    bus.ready_o = (count < 2'd2);
    bus.valid_o = (count != 2'd0);
    enq         = bus.valid_i && bus.ready_o;
    deq         = bus.valid_o && bus.ready_i;
  end

  // Pointer and occupancy update; flush wins over any concurrent enqueue/dequeue.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else if (bus.flush_i) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) tail <= ~tail;
      if (deq) head <= ~head;
      unique case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage; contents are don't-care while empty, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (enq && !bus.flush_i) mem[tail] <= in_entry;
  end

  // Head entry drives the outputs, forced to zero when the buffer is empty.
  always_comb begin
    head_entry = mem[head];
    if (count == 2'd0) head_entry = '0;
    bus.inst_o  = head_entry.inst;
    bus.pc_o    = head_entry.pc;
    bus.fmt_o   = head_entry.fmt;
    bus.imm_o   = head_entry.imm;
    bus.count_o = count;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps plus random traffic,
// compared against a queue-based model of the buffer and an arithmetic model
// of the immediate formats.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.WORD_SIZE_P(16), .PC_WIDTH_P(16)) bus ();
  decode_stage_if #(.WORD_SIZE_P(32), .PC_WIDTH_P(16)) wz ();
  decode_stage_if #(.WORD_SIZE_P(32), .PC_WIDTH_P(16)) ws ();

  decode_stage #(.WORD_SIZE_P(16), .PC_WIDTH_P(16), .SIGN_EXT_EN_P(1'b1)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus));
  decode_stage #(.WORD_SIZE_P(32), .PC_WIDTH_P(16), .SIGN_EXT_EN_P(1'b0)) u_w32z (
    .clk_i(clk), .reset_n_i(rst_n), .bus(wz));
  decode_stage #(.WORD_SIZE_P(32), .PC_WIDTH_P(16), .SIGN_EXT_EN_P(1'b1)) u_w32s (
    .clk_i(clk), .reset_n_i(rst_n), .bus(ws));

  typedef struct {
    logic [15:0] inst;
    logic [15:0] pc;
  } ent_t;

  ent_t q[$];
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Immediate from the format table, using shifts/masks and signed arithmetic.
  function automatic longint unsigned ref_imm(input logic [15:0] inst, input bit sext,
                                              input int unsigned w);
    int unsigned lo, n;
    bit sg;
    longint f;
    lo = 0; n = 8; sg = 1'b0;
    case (int'(inst) >> 13)
      0: begin lo = 0; n = 8;  end
      1: begin lo = 6; n = 3;  end
      2: begin lo = 0; n = 7;  end
      3: begin lo = 6; n = 5;  end
      4: begin lo = 0; n = 8;  sg = 1'b1; end
      5: begin lo = 0; n = 11; sg = 1'b1; end
      6: begin lo = 0; n = 6;  sg = 1'b1; end
      default: begin lo = 3; n = 4; end
    endcase
    f = (longint'(inst) >> lo) & ((longint'(1) << n) - 1);
    if (sg && sext && (((f >> (n - 1)) & 1) == 1)) f = f - (longint'(1) << n);
    return longint'(unsigned'(f & ((longint'(1) << w) - 1)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of the 16-bit instance against the model queue.
  task automatic check_main();
    logic [15:0] ei, ep;
    ei = '0; ep = '0;
    if (q.size() != 0) begin ei = q[0].inst; ep = q[0].pc; end
    chk("valid_o", 64'(bus.valid_o), 64'(q.size() != 0));
    chk("ready_o", 64'(bus.ready_o), 64'(q.size() < 2));
    chk("count_o", 64'(bus.count_o), 64'(q.size()));
    chk("inst_o",  64'(bus.inst_o),  64'(ei));
    chk("pc_o",    64'(bus.pc_o),    64'(ep));
    chk("fmt_o",   64'(bus.fmt_o),   64'(int'(ei) >> 13));
    chk("imm_o",   64'(bus.imm_o),   (q.size() != 0) ? ref_imm(ei, 1'b1, 16) : 64'd0);
  endtask

  // One clock: drive inputs now, advance the model across the edge, then check.
  task automatic step(input bit v, input logic [15:0] inst, input logic [15:0] pc,
                      input bit rdy, input bit fl, output bit acc);
    bit m_enq, m_deq;
    ent_t e;
    bus.valid_i = v; bus.inst_i = inst; bus.pc_i = pc;
    bus.ready_i = rdy; bus.flush_i = fl;
    m_enq = v && (q.size() < 2);
    m_deq = (q.size() != 0) && rdy;
    acc = m_enq;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (m_deq) void'(q.pop_front());
      if (m_enq) begin e.inst = inst; e.pc = pc; q.push_back(e); end
    end
    check_main();
  endtask

  initial begin
    bit acc;
    bit got;
    logic [15:0] ri, rp;
    logic [15:0] dir_inst [6];
    logic [15:0] dir_imm [6];

    dir_inst[0] = 16'hA7FF; dir_imm[0] = 16'hFFFF;
    dir_inst[1] = 16'h8080; dir_imm[1] = 16'hFF80;
    dir_inst[2] = 16'hC020; dir_imm[2] = 16'hFFE0;
    dir_inst[3] = 16'hE078; dir_imm[3] = 16'h000F;
    dir_inst[4] = 16'h21C0; dir_imm[4] = 16'h0007;
    dir_inst[5] = 16'h00AB; dir_imm[5] = 16'h00AB;

    bus.valid_i = 0; bus.inst_i = '0; bus.pc_i = '0; bus.ready_i = 0; bus.flush_i = 0;
    wz.valid_i = 0; wz.inst_i = '0; wz.pc_i = '0; wz.ready_i = 1; wz.flush_i = 0;
    ws.valid_i = 0; ws.inst_i = '0; ws.pc_i = '0; ws.ready_i = 1; ws.flush_i = 0;

    // Reset then idle.
    #23;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_count", 64'(bus.count_o), 64'd0);
    chk("idle_imm", 64'(bus.imm_o), 64'd0);
    check_main();

    // Format coverage: each bundle one cycle after acceptance, then drained.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, dir_inst[i], 16'(16'h100 + i), 1'b1, 1'b0, acc);
      chk("fmt_dir", 64'(bus.fmt_o), 64'(int'(dir_inst[i]) >> 13));
      chk("imm_dir", 64'(bus.imm_o), 64'(dir_imm[i]));
      chk("pc_dir",  64'(bus.pc_o),  64'(16'h100 + i));
      step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    end

    // Back-pressure: two accepted, third refused until ready_o rises.
    step(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0, acc);
    step(1'b1, 16'h4242, 16'h0012, 1'b0, 1'b0, acc);
    chk("bp_count", 64'(bus.count_o), 64'd2);
    chk("bp_ready", 64'(bus.ready_o), 64'd0);
    step(1'b1, 16'h6333, 16'h0014, 1'b0, 1'b0, acc);
    chk("bp_third_refused", 64'(acc), 64'd0);
    got = 1'b0;
    for (int t = 0; t < 6 && !got; t++) begin
      step(1'b1, 16'h6333, 16'h0014, 1'b1, 1'b0, acc);
      if (acc) begin
        got = 1'b1;
        chk("bp_accept_cycle", 64'(t), 64'd1);
      end
    end
    chk("bp_third_accepted", 64'(got), 64'd1);
    for (int t = 0; t < 3; t++) step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Streaming: sustained one bundle per cycle at occupancy 1.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'($urandom), 16'(16'h200 + i), 1'b1, 1'b0, acc);
      chk("stream_count", 64'(bus.count_o), 64'd1);
      chk("stream_pc", 64'(bus.pc_o), 64'(16'h200 + i));
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Flush at full occupancy drops everything including the concurrent input.
    step(1'b1, 16'h0A0A, 16'h0300, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0B0B, 16'h0302, 1'b0, 1'b0, acc);
    step(1'b1, 16'h0C0C, 16'h0304, 1'b1, 1'b1, acc);
    chk("flush_count", 64'(bus.count_o), 64'd0);
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("flush_gone", 64'(bus.valid_o), 64'd0);

    // Reset mid-stream clears the buffer asynchronously.
    step(1'b1, 16'h1234, 16'h0400, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5678, 16'h0402, 1'b0, 1'b0, acc);
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_count", 64'(bus.count_o), 64'd0);
    chk("arst_inst", 64'(bus.inst_o), 64'd0);
    #2 rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);

    // Wide instances: compat zero-extension versus sign-extension.
    wz.valid_i = 1; wz.inst_i = 16'hA7FF; ws.valid_i = 1; ws.inst_i = 16'hA7FF;
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    chk("w32_zext", 64'(wz.imm_o), 64'h0000_07FF);
    chk("w32_sext", 64'(ws.imm_o), 64'hFFFF_FFFF);
    wz.valid_i = 0; ws.valid_i = 0;
    step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 12; i++) begin
      ri = 16'($urandom);
      wz.valid_i = 1; wz.inst_i = ri; ws.valid_i = 1; ws.inst_i = ri;
      step(1'b0, '0, '0, 1'b1, 1'b0, acc);
      chk("w32z_imm", 64'(wz.imm_o), ref_imm(ri, 1'b0, 32));
      chk("w32s_imm", 64'(ws.imm_o), ref_imm(ri, 1'b1, 32));
      wz.valid_i = 0; ws.valid_i = 0;
      step(1'b0, '0, '0, 1'b1, 1'b0, acc);
    end

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      ri = 16'($urandom);
      rp = 16'($urandom);
      step($urandom_range(0, 3) != 0, ri, rp, $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0, acc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked successor to the front-end combinational immediate decoder.
- Accepts fetched instructions (with PC) over a valid/ready interface and selects and extends the immediate for one of eight instruction formats.
- Buffers the decoded bundle in a 2-entry skid buffer, so the decoded stream toward issue is fully registered and tolerates back-pressure.
- Supports flush (branch redirect) and a parametrised word/PC width.

Parameters:
- WORD_SIZE_P, 16, datapath/immediate width; legal range >= 16 (instruction is always 16 bits).
- PC_WIDTH_P, 16, width of the PC carried alongside each instruction.
- SIGN_EXT_EN_P, 1, 1 = formats 4/5/6 sign-extend; 0 = those formats zero-extend (compat mode).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush; discards all buffered entries.
- valid_i  in  1  instruction on inst_i/pc_i is valid.
- ready_o  out  1  stage can accept an instruction this cycle.
- inst_i  in  16  raw instruction.
- pc_i  in  PC_WIDTH_P  PC of inst_i.
- valid_o  out  1  decoded bundle on outputs is valid.
- ready_i  in  1  downstream accepts bundle.
- inst_o  out  16  instruction passthrough.
- pc_o  out  PC_WIDTH_P  PC passthrough.
- fmt_o  out  3  format code (inst[15:13]).
- imm_o  out  WORD_SIZE_P  extended immediate / register index.
- count_o  out  2  buffer occupancy 0..2.

Behaviour:
- Format select is fmt = inst_i[15:13]:
  - 0: zero-extend [7:0]
  - 1: zero-extend [8:6]
  - 2: zero-extend [6:0]
  - 3: zero-extend [10:6]
  - 4: sign-extend [7:0]
  - 5: sign-extend [10:0]
  - 6: sign-extend [5:0]
  - 7: zero-extend [6:3] (register index)
- When SIGN_EXT_EN_P = 0, formats 4, 5 and 6 zero-extend.
- Extension is combinational on the input side. The stored entry holds {inst, pc, fmt, imm}.
- Storage is a 2-entry FIFO (head/tail pointers, 1 bit each, plus count). Outputs come from the head entry.
- Enqueue occurs when valid_i && ready_o. Dequeue occurs when valid_o && ready_i.
- ready_o = (count < 2), derived from registered count only. There is no combinational path from ready_i to ready_o.
- valid_o = (count != 0).
- Latency: an instruction accepted at edge N appears on the outputs after edge N (cycle N+1) when the buffer was empty. Order is strictly FIFO.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. At count=1 this sustains 1 instruction/cycle. At count=2 no enqueue is possible (ready_o low); a dequeue drops count to 1 and ready_o rises the next cycle.
- Output data is held stable while valid_o && !ready_i.
- Pointers wrap modulo 2.
- flush_i has priority over enqueue and dequeue in the same cycle:
  - next state is count=0 with both pointers reset to 0;
  - any concurrent enqueue is dropped.
  - The upstream handshake still appears to complete (ready_o may be high); fetch must re-issue after redirect.
- Reset (asynchronous assert, synchronous-safe deassert by the top level) sets count=0, pointers=0, valid_o=0, ready_o=1 and count_o=0.
- Data outputs (inst_o, pc_o, fmt_o, imm_o) reset to 0 and read 0 whenever count=0.
- Reset mid-stream discards all entries immediately.
- The data storage array requires no reset, but output muxing forces zeros when empty.

Test Plan:
- Reset then idle: reset_n_i low then high, no valid_i -> valid_o=0, ready_o=1, count_o=0, imm_o=0.
- Format coverage (WORD=16): inst 0xA7FF -> fmt_o=5, imm_o=0xFFFF.
  - 0x8080 -> imm_o=0xFF80.
  - 0xC020 -> imm_o=0xFFE0.
  - 0xE078 -> imm_o=0x000F.
  - 0x21C0 -> imm_o=0x0007.
  - 0x00AB -> imm_o=0x00AB.
  - Each appears one cycle after acceptance with pc_o matching pc_i.
- Back-pressure: ready_i=0, push 3 back-to-back instructions -> first two accepted, count_o=2, ready_o=0 on third. Release ready_i -> outputs drain in order, third accepted the cycle after ready_o rises.
- Streaming: ready_i=1, valid_i=1 for 20 cycles -> 20 bundles out in order, count_o stays 1, no bubbles after the first.
- Flush: count=2, assert flush_i with valid_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0; the flushed-cycle input never appears.
- Width/mode: WORD_SIZE_P=32, SIGN_EXT_EN_P=0, inst 0xA7FF -> imm_o=0x000007FF. Same inst with SIGN_EXT_EN_P=1 -> imm_o=0xFFFFFFFF.
